rx_sample_framer: RTL and testbench

- Sits directly downstream of the RX frontend correction stage in the radio datapath.
- Consumes the corrected `rx_stb`/`rx_data` sample stream.
- Drives `rx_running` back to that stage.
- Packs samples into AXI-Stream packets of programmable length, with start/stop/count control from the radio settings bus and overflow detection with clean packet termination.

---
 rtl/rx_sample_framer.sv | 190 +++++++++++++++++++
 tb/tb_rx_sample_framer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_sample_framer.sv
// rx_sample_framer
// Packs the corrected RX sample stream into AXI-Stream packets of
// programmable length. Capture is started/stopped from the settings bus,
// optionally for a fixed number of samples. If the output FIFO backs up,
// the run is aborted: the open packet is closed with an error word
// (data 0, tlast=1, tuser=1) and the sticky overflow flag is raised.
//
// Optional feature: define RX_SAMPLE_FRAMER_OVF_COUNT_EN to build a 16-bit
// saturating overflow event counter on ovf_count; otherwise it reads 0.
//
// Ports:
//   clk, reset           core clock, synchronous active-high reset
//   set_stb/addr/data    settings bus write (SR_BASE+0 spp, +1 num_samps,
//                        +2 command: bit0 start, bit1 stop)
//   rx_stb, rx_data      sample stream in (I in [31:16], Q in [15:0])
//   rx_running           high while capturing, back to the RX frontend
//   o_tdata/tlast/tuser/tvalid, o_tready   AXI-Stream packet output
//   overflow             sticky overflow flag, cleared by accepted start
//   ovf_count            overflow event count (0 unless feature enabled)
module rx_sample_framer #(
    parameter logic [7:0]  SR_BASE   = 8'd180,
    parameter int          FIFO_SIZE = 5,
    parameter logic [15:0] SPP_RESET = 16'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic        rx_stb,
    input  logic [31:0] rx_data,
    output logic        rx_running,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tuser,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic        overflow,
    output logic [15:0] ovf_count
);

    localparam int DEPTH = 1 << FIFO_SIZE;
    // One slot is always kept free so an error word can close the packet.
    localparam logic [FIFO_SIZE:0] RESERVE_LVL = (FIFO_SIZE + 1)'(DEPTH - 1);
    localparam logic [7:0] ADDR_SPP   = SR_BASE;
    localparam logic [7:0] ADDR_NSAMP = SR_BASE + 8'd1;
    localparam logic [7:0] ADDR_CMD   = SR_BASE + 8'd2;

    typedef enum logic [1:0] {IDLE, RUN, STOPPING, OVF} state_t;

    state_t        state;
    logic [15:0]   spp_reg, spp_w, pkt_cnt, pkt_cnt_nxt;
    logic [31:0]   nsamps_reg, nsamps_w, remaining;

    logic [33:0]          mem [DEPTH];
    logic [FIFO_SIZE-1:0] wr_ptr, rd_ptr;
    logic [FIFO_SIZE:0]   fifo_cnt;
    logic [33:0]          head, push_word;

    logic cmd_wr, cmd_start, cmd_stop;
    logic active, smp, ovf_hit, smp_last, push, pop, done;

    // Stop wins over start when both bits are written together.
    assign cmd_wr    = set_stb && (set_addr == ADDR_CMD);
    assign cmd_start = cmd_wr && set_data[0] && !set_data[1];
    assign cmd_stop  = cmd_wr && set_data[1];

    assign active   = (state == RUN) || (state == STOPPING);
    assign smp      = active && rx_stb;
    assign ovf_hit  = smp && (fifo_cnt == RESERVE_LVL);
    assign smp_last = (pkt_cnt == spp_w - 16'd1) ||
                      ((nsamps_w != 32'd0) && (remaining == 32'd1)) ||
                      (state == STOPPING);
    assign pkt_cnt_nxt = smp_last ? 16'd0 : pkt_cnt + 16'd1;
    assign done     = smp && !ovf_hit && (nsamps_w != 32'd0) && (remaining == 32'd1);

    // An overflow with no open packet writes nothing.
    assign push      = smp && (!ovf_hit || (pkt_cnt != 16'd0));
    assign push_word = ovf_hit ? {32'h0, 1'b1, 1'b1} : {rx_data, smp_last, 1'b0};

    assign pop      = o_tvalid && o_tready;
    assign head     = mem[rd_ptr];
    assign o_tvalid = (fifo_cnt != '0);
    // Gate the head word so outputs read 0 whenever nothing is presented.
    assign o_tdata  = o_tvalid ? head[33:2] : 32'h0;
    assign o_tlast  = o_tvalid && head[1];
    assign o_tuser  = o_tvalid && head[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rx_running <= 1'b0;
            overflow   <= 1'b0;
            pkt_cnt    <= 16'd0;
            remaining  <= 32'd0;
            spp_reg    <= SPP_RESET;
            spp_w      <= SPP_RESET;
            nsamps_reg <= 32'd0;
            nsamps_w   <= 32'd0;
        end else begin
            if (set_stb && set_addr == ADDR_SPP)
                spp_reg <= (set_data[15:0] == 16'd0) ? 16'd1 : set_data[15:0];
            if (set_stb && set_addr == ADDR_NSAMP)
                nsamps_reg <= set_data;

            case (state)
                IDLE, OVF: begin
                    if (cmd_start) begin
                        state      <= RUN;
                        rx_running <= 1'b1;
                        overflow   <= 1'b0;
                        pkt_cnt    <= 16'd0;
                        remaining  <= nsamps_reg;
                        spp_w      <= spp_reg;
                        nsamps_w   <= nsamps_reg;
                    end
                end
                default: begin
                    if (ovf_hit) begin
                        state      <= OVF;
                        rx_running <= 1'b0;
                        overflow   <= 1'b1;
                        pkt_cnt    <= 16'd0;
                    end else begin
                        if (smp) begin
                            pkt_cnt <= pkt_cnt_nxt;
                            if (nsamps_w != 32'd0)
                                remaining <= remaining - 32'd1;
                        end
                        if (done || (smp && state == STOPPING)) begin
                            state      <= IDLE;
                            rx_running <= 1'b0;
                        end else if (state == RUN && cmd_stop) begin
                            // Judge the packet boundary after this cycle's sample.
                            if ((smp ? pkt_cnt_nxt : pkt_cnt) == 16'd0) begin
                                state      <= IDLE;
                                rx_running <= 1'b0;
                            end else begin
                                state <= STOPPING;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

`ifdef RX_SAMPLE_FRAMER_OVF_COUNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] ovf_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            ovf_cnt <= 16'h0;
        else if (ovf_hit)
            ovf_cnt <= sat_inc16(ovf_cnt);
    end

    assign ovf_count = ovf_cnt;
`else
    assign ovf_count = 16'h0;
`endif

endmodule

// File: tb/tb_rx_sample_framer.sv
// Directed testbench for rx_sample_framer (FIFO_SIZE=3, DEPTH=8).
// Accepted output words are captured on the falling edge; stimulus changes
// 1 time unit after the rising edge.
module tb_rx_sample_framer;

    localparam logic [7:0] A_SPP = 8'd180;
    localparam logic [7:0] A_NS  = 8'd181;
    localparam logic [7:0] A_CMD = 8'd182;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'h0;
    logic [31:0] set_data = 32'h0;
    logic        rx_stb = 1'b0;
    logic [31:0] rx_data = 32'h0;
    logic        rx_running;
    logic [31:0] o_tdata;
    logic        o_tlast, o_tuser, o_tvalid;
    logic        o_tready = 1'b1;
    logic        overflow;
    logic [15:0] ovf_count;

    rx_sample_framer #(.SR_BASE(8'd180), .FIFO_SIZE(3), .SPP_RESET(16'd64)) dut (
        .clk(clk), .reset(reset),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .rx_stb(rx_stb), .rx_data(rx_data), .rx_running(rx_running),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tuser(o_tuser),
        .o_tvalid(o_tvalid), .o_tready(o_tready),
        .overflow(overflow), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic        last;
    } vec_t;

    vec_t        vec [64];
    logic [33:0] q [$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic        toggle = 1'b0;
    logic [15:0] exp_ovf1, exp_ovf2;

    always @(negedge clk)
        if (o_tvalid && o_tready)
            q.push_back({o_tdata, o_tlast, o_tuser});

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle) o_tready = ~o_tready;
    endtask

    task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic wr_set(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        tick();
        set_stb = 1'b0;
    endtask

    task automatic send_range(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            rx_stb = 1'b1; rx_data = vec[base + i].din;
            tick();
        end
        rx_stb = 1'b0;
    endtask

    task automatic wait_words(input string nm, input int n);
        int cyc = 0;
        while (q.size() < n && cyc < 200) begin
            tick();
            cyc++;
        end
        repeat (3) tick();
        chk({nm, " word count"}, 34'(q.size()), 34'(n));
    endtask

    task automatic cmp_words(input string nm, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            if (i >= q.size()) begin
                n_chk++;
                $display("FAIL %s word %0d: missing, expected %h", nm, i, vec[base + i].din);
            end else begin
                chk($sformatf("%s word %0d", nm, i), q[i],
                    {vec[base + i].din, vec[base + i].last, 1'b0});
            end
        end
    endtask

    initial begin
        int lasts [12] = '{3, 7, 11, 14, 18, 19, 20, 21, 36, 41, 43, 51};
        for (int i = 0; i < 64; i++) begin
            vec[i].din  = {8'hC0, 8'(i), 16'h1234 + 16'(i)};
            vec[i].last = 1'b0;
        end
        foreach (lasts[k]) vec[lasts[k]].last = 1'b1;
`ifdef RX_SAMPLE_FRAMER_OVF_COUNT_EN
        exp_ovf1 = 16'd1; exp_ovf2 = 16'd2;
`else
        exp_ovf1 = 16'd0; exp_ovf2 = 16'd0;
`endif

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst tvalid", 34'(o_tvalid), 34'(0));
        chk("rst tdata", 34'(o_tdata), 34'(0));
        chk("rst running", 34'(rx_running), 34'(0));
        chk("rst overflow", 34'(overflow), 34'(0));
        chk("rst ovf_count", 34'(ovf_count), 34'(0));

        // T1: spp=4, num_samps=8, back-to-back
        wr_set(A_SPP, 32'd4);
        wr_set(A_NS, 32'd8);
        wr_set(A_CMD, 32'd1);
        chk("t1 running after start", 34'(rx_running), 34'(1));
        for (int i = 0; i < 8; i++) begin
            rx_stb = 1'b1; rx_data = vec[i].din;
            tick();
            chk($sformatf("t1 running after strobe %0d", i + 1), 34'(rx_running), 34'(i < 7));
        end
        rx_stb = 1'b0;
        wait_words("t1", 8);
        cmp_words("t1", 0, 8);
        q.delete();

        // T2: continuous, stop mid-packet, one more sample closes it
        wr_set(A_NS, 32'd0);
        wr_set(A_CMD, 32'd1);
        send_range(8, 6);
        wr_set(A_CMD, 32'd2);
        chk("t2 running while stopping", 34'(rx_running), 34'(1));
        send_range(14, 1);
        chk("t2 running after last", 34'(rx_running), 34'(0));
        wait_words("t2", 7);
        cmp_words("t2", 8, 7);
        q.delete();

        // T2b: stop on packet boundary -> IDLE at once, nothing written
        wr_set(A_CMD, 32'd1);
        send_range(15, 4);
        wr_set(A_CMD, 32'd2);
        chk("t2b running after stop", 34'(rx_running), 34'(0));
        wait_words("t2b", 4);
        cmp_words("t2b", 15, 4);
        q.delete();

        // T4: spp written 0 behaves as 1
        wr_set(A_SPP, 32'd0);
        wr_set(A_NS, 32'd3);
        wr_set(A_CMD, 32'd1);
        send_range(19, 3);
        chk("t4 running", 34'(rx_running), 34'(0));
        wait_words("t4", 3);
        cmp_words("t4", 19, 3);
        q.delete();

        // T3: overflow mid-packet, tready held low
        o_tready = 1'b0;
        wr_set(A_SPP, 32'd16);
        wr_set(A_NS, 32'd0);
        wr_set(A_CMD, 32'd1);
        send_range(22, 8);
        chk("t3 overflow", 34'(overflow), 34'(1));
        chk("t3 running", 34'(rx_running), 34'(0));
        chk("t3 ovf_count", 34'(ovf_count), 34'(exp_ovf1));
        tick(); tick();
        chk("t3 stalled tdata held", 34'(o_tdata), 34'(vec[22].din));
        chk("t3 stalled tvalid", 34'(o_tvalid), 34'(1));
        o_tready = 1'b1;
        wait_words("t3", 8);
        cmp_words("t3", 22, 7);
        if (q.size() > 7) chk("t3 error word", q[7], {32'h0, 1'b1, 1'b1});
        else begin n_chk++; $display("FAIL t3 error word: missing, expected %h", {32'h0, 2'b11}); end
        chk("t3 overflow sticky", 34'(overflow), 34'(1));
        q.delete();
        wr_set(A_CMD, 32'd1);
        chk("t3 restart clears overflow", 34'(overflow), 34'(0));
        chk("t3 restart running", 34'(rx_running), 34'(1));
        wr_set(A_CMD, 32'd2);
        chk("t3 stop idle", 34'(rx_running), 34'(0));

        // T3b: overflow exactly on a packet boundary writes nothing
        o_tready = 1'b0;
        wr_set(A_SPP, 32'd7);
        wr_set(A_CMD, 32'd1);
        send_range(30, 8);
        chk("t3b overflow", 34'(overflow), 34'(1));
        chk("t3b ovf_count", 34'(ovf_count), 34'(exp_ovf2));
        o_tready = 1'b1;
        wait_words("t3b", 7);
        cmp_words("t3b", 30, 7);
        q.delete();

        // T6: ignored commands, tready toggling
        wr_set(A_CMD, 32'd3);
        chk("t6 start|stop in OVF running", 34'(rx_running), 34'(0));
        chk("t6 start|stop in OVF overflow", 34'(overflow), 34'(1));
        wr_set(A_CMD, 32'd1);
        wr_set(A_CMD, 32'd2);
        wr_set(A_CMD, 32'd3);
        chk("t6 start|stop in IDLE", 34'(rx_running), 34'(0));
        wr_set(A_SPP, 32'd4);
        wr_set(A_NS, 32'd6);
        wr_set(A_CMD, 32'd1);
        toggle = 1'b1;
        send_range(38, 2);
        wr_set(A_CMD, 32'd1);
        chk("t6 running after restart attempt", 34'(rx_running), 34'(1));
        send_range(40, 4);
        chk("t6 running after count", 34'(rx_running), 34'(0));
        wait_words("t6", 6);
        toggle = 1'b0;
        o_tready = 1'b1;
        cmp_words("t6", 38, 6);
        q.delete();

        // T5: reset mid-run drops the partial packet
        o_tready = 1'b0;
        wr_set(A_SPP, 32'd8);
        wr_set(A_NS, 32'd0);
        wr_set(A_CMD, 32'd1);
        for (int i = 0; i < 5; i++) begin
            rx_stb = 1'b1; rx_data = 32'hDEAD_0000 + 32'(i);
            tick();
        end
        rx_stb = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5 tvalid", 34'(o_tvalid), 34'(0));
        chk("t5 tdata", 34'(o_tdata), 34'(0));
        chk("t5 tlast", 34'(o_tlast), 34'(0));
        chk("t5 tuser", 34'(o_tuser), 34'(0));
        chk("t5 running", 34'(rx_running), 34'(0));
        chk("t5 ovf_count", 34'(ovf_count), 34'(0));
        o_tready = 1'b1;
        wait_words("t5 after reset", 0);
        wr_set(A_SPP, 32'd8);
        wr_set(A_CMD, 32'd1);
        send_range(44, 8);
        wr_set(A_CMD, 32'd2);
        chk("t5 stop on boundary", 34'(rx_running), 34'(0));
        wait_words("t5", 8);
        cmp_words("t5", 44, 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
